// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates CPU (A) and DMA (B) onto one data memory; define ARB_ROUND_ROBIN_EN for round-robin ties, else A wins ties.
// Latency: req sampled at edge N, memory access during the next cycle, ack/err/rdata the cycle after; one transaction per 3 cycles.
// Backpressure: requesters hold req and command until ack; a losing requester waits for the next IDLE arbitration.
module data_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        we_a,
    input  logic [31:0] addr_a,
    input  logic [31:0] wdata_a,
    output logic        ack_a,
    output logic        err_a,
    output logic [31:0] rdata_a,
    input  logic        req_b,
    input  logic        we_b,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_b,
    output logic        ack_b,
    output logic        err_b,
    output logic [31:0] rdata_b,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_ack_a, r_ack_b, r_err_a, r_err_b;
    logic [31:0] r_rdata_a, r_rdata_b;

    logic        w_any_req, w_grant_b, w_in_access, w_own_we, w_addr_err;
    logic [31:0] w_own_addr, w_own_wdata, w_capture;

    assign w_any_req = req_a | req_b;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // A tie goes to whoever did not win last; resetting to B lets A take the first tie.
    assign w_grant_b = req_b & (~req_a | ~r_last_grant);

    always_ff @(posedge clk) begin
        if (rst)
            r_last_grant <= 1'b1;
        else if (r_state == S_IDLE && w_any_req)
            r_last_grant <= w_grant_b;
    end
`else
    assign w_grant_b = req_b & ~req_a;
`endif

    assign w_in_access = (r_state == S_ACCESS);
    assign w_own_we    = r_owner ? we_b    : we_a;
    assign w_own_addr  = r_owner ? addr_b  : addr_a;
    assign w_own_wdata = r_owner ? wdata_b : wdata_a;
    assign w_addr_err  = |w_own_addr[31:8];
    // read_data is the pre-write word because the write only lands on the edge ending ACCESS.
    assign w_capture   = w_addr_err ? 32'h0 : read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;
            r_rdata_a <= 32'h0;
            r_rdata_b <= 32'h0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_err_a <= 1'b0;
            r_err_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_b;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                    if (r_owner) begin
                        r_ack_b   <= 1'b1;
                        r_err_b   <= w_addr_err;
                        r_rdata_b <= w_capture;
                    end else begin
                        r_ack_a   <= 1'b1;
                        r_err_a   <= w_addr_err;
                        r_rdata_a <= w_capture;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // rst gates the strobe so an aborted ACCESS never writes on the reset edge.
    assign mem_write  = w_in_access & w_own_we & ~w_addr_err & ~rst;
    assign address    = w_in_access ? w_own_addr  : 32'h0;
    assign write_data = w_in_access ? w_own_wdata : 32'h0;

    assign ack_a   = r_ack_a;
    assign ack_b   = r_ack_b;
    assign err_a   = r_err_a;
    assign err_b   = r_err_b;
    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign busy    = (r_state != S_IDLE);

endmodule
